// File: rtl/msrv32_decoder_pipe.sv
// msrv32_decoder_pipe
//   Registered decode stage between instruction fetch and execute/writeback.
//   The incoming instruction word is decoded combinationally into a control
//   bundle. The bundle is captured on an input handshake and presented one
//   cycle later. A main register plus one skid register let fetch and
//   execute stall independently without losing or repeating entries.
//
// Parameters
//   XLEN      32 or 64; 64 adds LD/SD/LWU decode
//   ADDR_LSB  width of iadder_lsb_in (must be >= 3 when XLEN = 64)
//
// Ports
//   ms_riscv32_mp_clk_in     core clock
//   ms_riscv32_mp_rst_n_in   asynchronous active-low reset
//   instr_in / iadder_lsb_in instruction word, low load/store address bits
//   instr_valid_in / instr_ready_out   upstream handshake
//   flush_in                 drop every buffered entry (highest priority)
//   trap_taken_in            suppresses mem_wr_req_out in the current cycle
//   dec_valid_out / dec_ready_in       downstream handshake
//   alu_opcode_out .. misaligned_store_out   decoded bundle (0 when idle)
//
// Optional build macro
//   MSRV32_DEC_ILLEGAL_CNT_EN adds illegal_cnt_out, a saturating count of
//   illegal instructions handed downstream.
module msrv32_decoder_pipe #(
   parameter int XLEN     = 32,
   parameter int ADDR_LSB = 3
) (
   input  logic                ms_riscv32_mp_clk_in,
   input  logic                ms_riscv32_mp_rst_n_in,
   input  logic [31:0]         instr_in,
   input  logic [ADDR_LSB-1:0] iadder_lsb_in,
   input  logic                instr_valid_in,
   output logic                instr_ready_out,
   input  logic                flush_in,
   input  logic                trap_taken_in,
   output logic                dec_valid_out,
   input  logic                dec_ready_in,
   output logic [3:0]          alu_opcode_out,
   output logic [1:0]          load_size_out,
   output logic                load_unsigned_out,
   output logic                alu_src_out,
   output logic                iadder_src_out,
   output logic                rf_wr_en_out,
   output logic                csr_wr_en_out,
   output logic                mem_wr_req_out,
   output logic [2:0]          wb_mux_sel_out,
   output logic [2:0]          imm_type_out,
   output logic [2:0]          csr_op_out,
   output logic                illegal_instr_out,
   output logic                misaligned_load_out,
   output logic                misaligned_store_out
`ifdef MSRV32_DEC_ILLEGAL_CNT_EN
   ,
   output logic [15:0]         illegal_cnt_out
`endif
);

   typedef struct packed {
      logic [3:0] alu_opcode;
      logic [1:0] load_size;
      logic       load_unsigned;
      logic       alu_src;
      logic       iadder_src;
      logic       rf_wr_en;
      logic       csr_wr_en;
      logic       store_ok;
      logic [2:0] wb_mux_sel;
      logic [2:0] imm_type;
      logic [2:0] csr_op;
      logic       illegal;
      logic       mis_load;
      logic       mis_store;
   } bundle_t;

   // ---- stage p0: combinational decode of the incoming word ----
   logic [2:0] lsb3;
   generate
      if (ADDR_LSB >= 3) begin : g_lsb_wide
         assign lsb3 = iadder_lsb_in[2:0];
      end else begin : g_lsb_narrow
         assign lsb3 = {{(3-ADDR_LSB){1'b0}}, iadder_lsb_in};
      end
   endgenerate

   // Fields of the word that the decoder does not look at.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{instr_in[31], instr_in[29:15], instr_in[11:7]};

   logic [4:0] opc;
   logic [2:0] f3;
   logic       std_len;
   logic       is_op, is_op_imm, is_load, is_store, is_branch, is_jal, is_jalr;
   logic       is_lui, is_auipc, is_misc_mem, is_system, is_csr;
   logic       known_opc, width_bad, size_mis;
   bundle_t    dec_p0;

   assign opc     = instr_in[6:2];
   assign f3      = instr_in[14:12];
   assign std_len = (instr_in[1:0] == 2'b11);

   // Class flags are only raised for 32-bit encodings, so a compressed or
   // reserved length field yields an illegal word with no side effects.
   assign is_op       = std_len & (opc == 5'b01100);
   assign is_op_imm   = std_len & (opc == 5'b00100);
   assign is_load     = std_len & (opc == 5'b00000);
   assign is_store    = std_len & (opc == 5'b01000);
   assign is_branch   = std_len & (opc == 5'b11000);
   assign is_jal      = std_len & (opc == 5'b11011);
   assign is_jalr     = std_len & (opc == 5'b11001);
   assign is_lui      = std_len & (opc == 5'b01101);
   assign is_auipc    = std_len & (opc == 5'b00101);
   assign is_misc_mem = std_len & (opc == 5'b00011);
   assign is_system   = std_len & (opc == 5'b11100);
   assign is_csr      = is_system & (f3 != 3'b000);

   assign known_opc = is_op | is_op_imm | is_load | is_store | is_branch | is_jal |
                      is_jalr | is_lui | is_auipc | is_misc_mem | is_system;

   // RV64 opens funct3=011 to both loads and stores and 110 (LWU) to loads.
   assign width_bad = (XLEN == 64) ?
                      (((is_load | is_store) & (f3 == 3'b111)) | (is_store & (f3 == 3'b110))) :
                      (((is_load | is_store) & (f3[1:0] == 2'b11)) | (is_load & (f3 == 3'b110)));

   always_comb begin
      size_mis = 1'b0;
      case (f3[1:0])
         2'b01:   size_mis = lsb3[0];
         2'b10:   size_mis = |lsb3[1:0];
         2'b11:   size_mis = |lsb3;
         default: size_mis = 1'b0;
      endcase
   end

   always_comb begin
      dec_p0               = '0;
      dec_p0.alu_opcode    = {instr_in[30] & ~(is_op_imm & (f3 != 3'b101)), f3};
      dec_p0.load_size     = f3[1:0];
      dec_p0.load_unsigned = f3[2];
      dec_p0.alu_src       = instr_in[5];
      dec_p0.iadder_src    = is_load | is_store | is_jalr;
      dec_p0.rf_wr_en      = is_lui | is_auipc | is_jal | is_jalr | is_op | is_op_imm |
                             is_load | is_csr;
      dec_p0.csr_wr_en     = is_csr;
      dec_p0.store_ok      = is_store & ~width_bad & ~size_mis;
      dec_p0.wb_mux_sel    = {is_csr | is_jal | is_jalr,
                              is_lui | is_auipc,
                              is_load | is_auipc | is_jal | is_jalr};
      dec_p0.imm_type      = {is_lui | is_auipc | is_jal | is_csr,
                              is_store | is_branch | is_csr,
                              is_op_imm | is_load | is_jalr | is_branch | is_jal};
      dec_p0.csr_op        = f3;
      dec_p0.illegal       = ~known_opc | width_bad;
      dec_p0.mis_load      = is_load & ~width_bad & size_mis;
      dec_p0.mis_store     = is_store & ~width_bad & size_mis;
   end

   // ---- stage p1: main output register plus skid register ----
   logic    main_vld_p1, skid_vld_p1, ready_p1;
   bundle_t main_p1, skid_p1;
   logic    in_hs, main_free, skid_vld_nxt;

   assign in_hs        = instr_valid_in & ready_p1;
   assign main_free    = ~main_vld_p1 | dec_ready_in;
   // Skid is only ever filled while main is stalled, and empties into main
   // as soon as main drains; ready is the registered inverse of its state.
   assign skid_vld_nxt = ~main_free & (skid_vld_p1 | in_hs);

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         main_vld_p1 <= 1'b0;
         skid_vld_p1 <= 1'b0;
         ready_p1    <= 1'b0;
      end else if (flush_in) begin
         main_vld_p1 <= 1'b0;
         skid_vld_p1 <= 1'b0;
         ready_p1    <= 1'b1;
      end else begin
         if (main_free) begin
            main_vld_p1 <= skid_vld_p1 | in_hs;
         end
         skid_vld_p1 <= skid_vld_nxt;
         ready_p1    <= ~skid_vld_nxt;
      end
   end

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (main_free) begin
         if (skid_vld_p1) begin
            main_p1 <= skid_p1;
         end else if (in_hs) begin
            main_p1 <= dec_p0;
         end
      end else if (in_hs) begin
         skid_p1 <= dec_p0;
      end
   end

   bundle_t out_b;
   assign out_b = main_vld_p1 ? main_p1 : '0;

   assign instr_ready_out      = ready_p1;
   assign dec_valid_out        = main_vld_p1;
   assign alu_opcode_out       = out_b.alu_opcode;
   assign load_size_out        = out_b.load_size;
   assign load_unsigned_out    = out_b.load_unsigned;
   assign alu_src_out          = out_b.alu_src;
   assign iadder_src_out       = out_b.iadder_src;
   assign rf_wr_en_out         = out_b.rf_wr_en;
   assign csr_wr_en_out        = out_b.csr_wr_en;
   assign mem_wr_req_out       = out_b.store_ok & ~trap_taken_in;
   assign wb_mux_sel_out       = out_b.wb_mux_sel;
   assign imm_type_out         = out_b.imm_type;
   assign csr_op_out           = out_b.csr_op;
   assign illegal_instr_out    = out_b.illegal;
   assign misaligned_load_out  = out_b.mis_load;
   assign misaligned_store_out = out_b.mis_store;

`ifdef MSRV32_DEC_ILLEGAL_CNT_EN
   logic [15:0] ill_cnt_p2;
   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         ill_cnt_p2 <= 16'h0000;
      end else if (main_vld_p1 & dec_ready_in & main_p1.illegal & (ill_cnt_p2 != 16'hFFFF)) begin
         ill_cnt_p2 <= ill_cnt_p2 + 16'h0001;
      end
   end
   assign illegal_cnt_out = ill_cnt_p2;
`endif

endmodule
